// File: rtl/data_memory_stage.sv
// MEM stage of the 5-stage ARM pipeline: word/byte loads and stores to a local
// data memory with a fixed access latency, stalling upstream while busy.
module data_memory_stage #(
   parameter int DEPTH       = 256,
   parameter int ADDR_BITS   = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] aluResult,
   input  logic [31:0] storeData,
   input  logic [3:0]  rd_In,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        byteAccess,
   input  logic        linkBit,
   input  logic        writebackEnable,
   input  logic [3:0]  CPSRStatus_In,
   output logic [31:0] dataMemOut,
   output logic [3:0]  rd_Out,
   output logic        linkBit_Out,
   output logic        writebackEnable_Out,
   output logic [3:0]  CPSRStatus_Out,
   output logic        stall
);

   localparam int DATA_W = 32;
   localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          cnt;
   logic [3:0]          cnt_nxt;
   logic [DATA_W-1:0]   read_buf;
   logic                op_store;
   logic                mem_op;
   logic                access_now;
   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]          lane;

   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   function automatic logic [DATA_W-1:0] byte_extract(input logic [DATA_W-1:0] w,
                                                      input logic [1:0] ln);
      return {24'b0, w[{ln, 3'b000} +: 8]};
   endfunction

   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] ln,
                                                    input logic [7:0] b);
      logic [DATA_W-1:0] r;
      r = w;
      r[{ln, 3'b000} +: 8] = b;
      return r;
   endfunction

   assign mem_op   = memRead | memWrite;
   assign word_idx = aluResult[ADDR_BITS+1:2];
   assign lane     = aluResult[1:0];

   // The access edge is the last stalled cycle; memory is touched only then.
   assign access_now = ((state == IDLE) && mem_op && (MEM_LATENCY == 1)) ||
                       ((state == ACCESS) && (cnt == LAST_CNT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         op_store <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (access_now)
            op_store <= memWrite;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (mem_op) begin
               if (MEM_LATENCY == 1) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = 4'd1;
                  state_nxt = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (cnt == LAST_CNT)
               state_nxt = DONE;
            else
               cnt_nxt = cnt + 4'd1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         read_buf <= '0;
      else if (access_now && !memWrite)
         read_buf <= byteAccess ? byte_extract(mem[word_idx], lane) : mem[word_idx];
   end

   // Memory is not cleared by reset, but a reset cancels any pending write.
   always_ff @(posedge clk) begin
      if (!reset && access_now && memWrite)
         mem[word_idx] <= byteAccess ? byte_merge(mem[word_idx], lane, storeData[7:0])
                                     : storeData;
   end

   always_comb begin
      dataMemOut          = aluResult;
      rd_Out              = rd_In;
      linkBit_Out         = linkBit;
      writebackEnable_Out = writebackEnable;
      CPSRStatus_Out      = CPSRStatus_In;
      stall               = 1'b0;
      if (reset) begin
         dataMemOut          = '0;
         rd_Out              = '0;
         linkBit_Out         = 1'b0;
         writebackEnable_Out = 1'b0;
         CPSRStatus_Out      = '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  stall               = 1'b1;
                  linkBit_Out         = 1'b0;
                  writebackEnable_Out = 1'b0;
               end
            end
            ACCESS: begin
               stall               = 1'b1;
               linkBit_Out         = 1'b0;
               writebackEnable_Out = 1'b0;
            end
            DONE: begin
               if (op_store)
                  writebackEnable_Out = 1'b0;
               else
                  dataMemOut = read_buf;
            end
            default: stall = 1'b0;
         endcase
      end
   end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
- MEM stage of the 5-stage ARM pipeline.
- Consumes EX/MEM register outputs and performs word/byte loads and stores to a local data memory with configurable access latency.
- Produces data, destination register, link, writeback-enable and flag fields that feed the MEM/WB pipeline register.
- Asserts stall to freeze upstream stages while a multi-cycle access is in flight, and injects a bubble downstream during that time.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of two).
- ADDR_BITS, 8, log2(DEPTH); word index width.
- MEM_LATENCY, 2, stall cycles per memory access (>=1, <=15).

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- aluResult  input  32  effective address (memory ops) or ALU result (non-memory ops).
- storeData  input  32  Rd value for stores.
- rd_In  input  4  destination register.
- memRead  input  1  load request.
- memWrite  input  1  store request.
- byteAccess  input  1  1 = byte (LDRB/STRB), 0 = word.
- linkBit  input  1  link flag from EX.
- writebackEnable  input  1  register write request from EX.
- CPSRStatus_In  input  4  NZCV flags from EX.
- dataMemOut  output  32  load data or aluResult pass-through.
- rd_Out  output  4  destination register.
- linkBit_Out  output  1  link flag, gated.
- writebackEnable_Out  output  1  register write request, gated.
- CPSRStatus_Out  output  4  flags pass-through.
- stall  output  1  1 = upstream must hold its inputs stable.

Behaviour:
- memOp = memRead | memWrite. If both memRead and memWrite are set, treat as a store.
- States: IDLE, ACCESS, DONE. A 4-bit counter cnt tracks latency.
- Reset: state = IDLE, cnt = 0, readBuf = 0, stall = 0.
  - While reset is high, all outputs are 0.
  - An in-flight store whose access edge has not occurred is discarded.
  - Memory contents are not cleared by reset; the array initialises to 0 at time zero.
- IDLE, memOp = 0:
  - stall = 0.
  - dataMemOut = aluResult.
  - Remaining outputs are combinational copies of their inputs.
  - Zero latency; state remains IDLE.
- IDLE, memOp = 1:
  - stall = 1.
  - If MEM_LATENCY = 1, the access is performed on this edge, then state goes to DONE.
  - Otherwise cnt <= 1 and state goes to ACCESS.
- ACCESS:
  - stall = 1.
  - If cnt == MEM_LATENCY-1, the access is performed on this edge, then state goes to DONE.
  - Otherwise cnt <= cnt+1.
- Stall length: stall is high for exactly MEM_LATENCY consecutive cycles per access.
- DONE (one cycle):
  - stall = 0.
  - Load: dataMemOut = readBuf.
  - Store: dataMemOut = aluResult.
  - Upstream advances on this edge; next state is IDLE.
  - Back-to-back memory ops re-enter via IDLE, so each op costs MEM_LATENCY+1 cycles.
- Bubble injection: while stall = 1, writebackEnable_Out = 0 and linkBit_Out = 0. rd_Out, CPSRStatus_Out and dataMemOut are don't-care but driven.
- Stores: writebackEnable_Out is forced to 0 in DONE.
- Addressing:
  - Word index = aluResult[ADDR_BITS+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Word access ignores aluResult[1:0].
- Byte lanes: little-endian, lane = aluResult[1:0].
  - Byte load zero-extends the selected lane into readBuf.
  - Byte store writes storeData[7:0] to that lane only; other lanes are unchanged.
- Input stability: inputs are sampled on the access edge. Upstream guarantees they are stable while stall = 1.

Test Plan:
- Reset then pass-through: memOp = 0, aluResult = 0x0000_1234, rd_In = 3, writebackEnable = 1 -> same cycle dataMemOut = 0x1234, rd_Out = 3, writebackEnable_Out = 1, stall = 0.
- Word store then load, MEM_LATENCY = 2: STR 0xDEADBEEF at address 0x10 -> stall high 2 cycles, writebackEnable_Out = 0 throughout; then LDR from 0x10 -> stall 2 cycles, DONE cycle gives dataMemOut = 0xDEADBEEF, writebackEnable_Out = 1.
- Byte ops: STRB 0xAA to 0x13 over word 0x11223344 -> word reads 0xAA223344; LDRB from 0x12 -> dataMemOut = 0x00000022.
- Wrap-around: with DEPTH = 256, a store to 0x400 followed by a load from 0x000 returns the stored value.
- Reset mid-access: assert reset in ACCESS of a store with MEM_LATENCY = 3 -> next cycle stall = 0, state IDLE, target word unchanged.
- MEM_LATENCY = 1, back-to-back LDRs -> stall pattern 1,0,1,0; each DONE cycle returns the correct data.
